flit_rx_monitor: RTL and testbench

// - Receiving end of the router flit link: sinks {data,valid,vch} flits on a mux/crossbar output port.
// - Tracks HEAD/DATA/TAIL framing, reports per-packet length and VC, counts packets and flits.
// - Accumulates the Hamming distance between successive valid flits (switching activity) for energy characterization.
// - Sits behind the mux under test in characterization benches and on router output ports as a protocol checker.

---
 rtl/noc_flit_pkg.sv | 25 ++
 rtl/flit_popcount.sv | 18 +
 rtl/flit_rx_monitor.sv | 178 +++++++++++++++++
 tb/tb_flit_rx_monitor.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_flit_pkg.sv
// Shared flit-link definitions: flit type encoding, receiver FSM states and
// sticky error bit positions.
package noc_flit_pkg;

    localparam int TYPE_W = 3;

    typedef enum logic [TYPE_W-1:0] {
        TYPE_NONE = 3'd0,
        TYPE_HEAD = 3'd1,
        TYPE_DATA = 3'd2,
        TYPE_TAIL = 3'd3
    } flit_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } rx_state_e;

    localparam int ERR_W           = 4;
    localparam int ERR_ORPHAN      = 0;
    localparam int ERR_HEAD_IN_PKT = 1;
    localparam int ERR_VCH_CHANGE  = 2;
    localparam int ERR_LEN_OVF     = 3;

endpackage

// File: rtl/flit_popcount.sv
// Combinational population count of one flit; feeds the switching-activity
// accumulator in the receive monitor.
module flit_popcount #(
    parameter int DATA_W = 67,
    parameter int POP_W  = $clog2(DATA_W + 1)
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [POP_W-1:0]  o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < DATA_W; i++) begin
            o_count = o_count + POP_W'(i_data[i]);
        end
    end

endmodule

// File: rtl/flit_rx_monitor.sv
// Flit link receiver/protocol checker: tracks HEAD/DATA/TAIL framing, reports
// packet length and VC, and keeps saturating packet/flit/toggle statistics.
module flit_rx_monitor
    import noc_flit_pkg::*;
#(
    parameter int DATA_W = 67,
    parameter int VCH_W  = 2,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [DATA_W-1:0] idata,
    input  logic              ivalid,
    input  logic [VCH_W-1:0]  ivch,
    input  logic              clr,
    output logic              busy,
    output logic              pkt_done,
    output logic [LEN_W-1:0]  pkt_len,
    output logic [VCH_W-1:0]  pkt_vch,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  flit_cnt,
    output logic [CNT_W-1:0]  toggle_cnt,
    output logic              err,
    output logic [ERR_W-1:0]  err_code
);

    localparam int               POP_W   = $clog2(DATA_W + 1);
    localparam int               ACC_W   = CNT_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = '1;

    rx_state_e         r_state;
    logic [LEN_W-1:0]  r_len;
    logic [VCH_W-1:0]  r_vch;
    logic [DATA_W-1:0] r_prev_flit;
    logic              r_pkt_done;
    logic [LEN_W-1:0]  r_pkt_len;
    logic [VCH_W-1:0]  r_pkt_vch;
    logic [CNT_W-1:0]  r_pkt_cnt;
    logic [CNT_W-1:0]  r_flit_cnt;
    logic [CNT_W-1:0]  r_toggle_cnt;
    logic              r_err;
    logic [ERR_W-1:0]  r_err_code;

    rx_state_e         w_state_nxt;
    logic [LEN_W-1:0]  w_len_nxt;
    logic [VCH_W-1:0]  w_vch_nxt;
    logic [LEN_W-1:0]  w_len_inc;
    logic [ERR_W-1:0]  w_err_set;
    logic [ERR_W-1:0]  w_err_code_nxt;
    logic              w_done;
    flit_type_e        w_type;
    logic [POP_W-1:0]  w_pop;
    logic [ACC_W-1:0]  w_tog_sum;

    assign w_type = flit_type_e'(idata[DATA_W-1 -: TYPE_W]);

    flit_popcount #(
        .DATA_W (DATA_W),
        .POP_W  (POP_W)
    ) u_popcount (
        .i_data  (idata ^ r_prev_flit),
        .o_count (w_pop)
    );

    assign w_tog_sum      = {1'b0, r_toggle_cnt} + ACC_W'(w_pop);
    assign w_err_code_nxt = r_err_code | w_err_set;
    // Length including the current flit, held at MAX_LEN once saturated.
    assign w_len_inc      = (r_len == MAX_LEN) ? MAX_LEN : r_len + LEN_W'(1);

    // NOTE: every signal driven here gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_vch_nxt   = r_vch;
        w_err_set   = '0;
        w_done      = 1'b0;
        if (ivalid) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_type == TYPE_HEAD) begin
                        w_state_nxt = ST_BODY;
                        w_len_nxt   = LEN_W'(1);
                        w_vch_nxt   = ivch;
                    end else begin
                        w_err_set[ERR_ORPHAN] = 1'b1;
                    end
                end
                ST_BODY: begin
                    if (w_type == TYPE_HEAD) begin
                        w_err_set[ERR_HEAD_IN_PKT] = 1'b1;
                        w_len_nxt                  = LEN_W'(1);
                        w_vch_nxt                  = ivch;
                    end else if (w_type == TYPE_DATA || w_type == TYPE_TAIL) begin
                        w_err_set[ERR_VCH_CHANGE] = (ivch != r_vch);
                        w_err_set[ERR_LEN_OVF]    = (r_len == MAX_LEN);
                        w_len_nxt                 = w_len_inc;
                        if (w_type == TYPE_TAIL) begin
                            w_done      = 1'b1;
                            w_state_nxt = ST_IDLE;
                            w_len_nxt   = '0;
                        end
                    end else begin
                        w_err_set[ERR_ORPHAN] = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_vch   <= '0;
        end else if (clr) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_vch   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_vch   <= w_vch_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_prev_flit  <= '0;
            r_pkt_done   <= 1'b0;
            r_pkt_len    <= '0;
            r_pkt_vch    <= '0;
            r_pkt_cnt    <= '0;
            r_flit_cnt   <= '0;
            r_toggle_cnt <= '0;
            r_err        <= 1'b0;
            r_err_code   <= '0;
        end else if (clr) begin
            r_prev_flit  <= '0;
            r_pkt_done   <= 1'b0;
            r_pkt_len    <= '0;
            r_pkt_vch    <= '0;
            r_pkt_cnt    <= '0;
            r_flit_cnt   <= '0;
            r_toggle_cnt <= '0;
            r_err        <= 1'b0;
            r_err_code   <= '0;
        end else begin
            r_pkt_done <= w_done;
            r_err_code <= w_err_code_nxt;
            r_err      <= |w_err_code_nxt;
            if (w_done) begin
                r_pkt_len <= w_len_inc;
                r_pkt_vch <= r_vch;
                if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
            end
            // Statistics count every valid flit, including ones flagged as errors.
            if (ivalid) begin
                r_prev_flit  <= idata;
                if (r_flit_cnt != '1) r_flit_cnt <= r_flit_cnt + CNT_W'(1);
                r_toggle_cnt <= w_tog_sum[CNT_W] ? '1 : w_tog_sum[CNT_W-1:0];
            end
        end
    end

    assign busy       = (r_state == ST_BODY);
    assign pkt_done   = r_pkt_done;
    assign pkt_len    = r_pkt_len;
    assign pkt_vch    = r_pkt_vch;
    assign pkt_cnt    = r_pkt_cnt;
    assign flit_cnt   = r_flit_cnt;
    assign toggle_cnt = r_toggle_cnt;
    assign err        = r_err;
    assign err_code   = r_err_code;

endmodule

// File: tb/tb_flit_rx_monitor.sv
// Directed bench for flit_rx_monitor: a framing vector table plus hand-written
// sequences for long packets, bubbles, toggle counting, overflow and clear.
module tb_flit_rx_monitor;
    import noc_flit_pkg::*;

    localparam int DATA_W = 67;
    localparam int VCH_W  = 2;
    localparam int CNT_W  = 32;

    logic              clk;
    logic              rst_;
    logic [DATA_W-1:0] idata;
    logic              ivalid;
    logic [VCH_W-1:0]  ivch;
    logic              clr;

    logic              busy, pkt_done, err;
    logic [7:0]        pkt_len;
    logic [VCH_W-1:0]  pkt_vch;
    logic [CNT_W-1:0]  pkt_cnt, flit_cnt, toggle_cnt;
    logic [3:0]        err_code;

    logic              s_busy, s_pkt_done, s_err;
    logic [2:0]        s_pkt_len;
    logic [VCH_W-1:0]  s_pkt_vch;
    logic [CNT_W-1:0]  s_pkt_cnt, s_flit_cnt, s_toggle_cnt;
    logic [3:0]        s_err_code;

    int n_cmp  = 0;
    int n_fail = 0;

    flit_rx_monitor dut (
        .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch), .clr(clr),
        .busy(busy), .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_vch(pkt_vch),
        .pkt_cnt(pkt_cnt), .flit_cnt(flit_cnt), .toggle_cnt(toggle_cnt),
        .err(err), .err_code(err_code)
    );

    flit_rx_monitor #(.LEN_W(3)) dut_short (
        .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch), .clr(clr),
        .busy(s_busy), .pkt_done(s_pkt_done), .pkt_len(s_pkt_len), .pkt_vch(s_pkt_vch),
        .pkt_cnt(s_pkt_cnt), .flit_cnt(s_flit_cnt), .toggle_cnt(s_toggle_cnt),
        .err(s_err), .err_code(s_err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one valid flit at a falling edge, then hold ivalid low for gap cycles.
    task automatic send(input flit_type_e t, input logic [VCH_W-1:0] v,
                        input logic [63:0] payload, input int gap);
        @(negedge clk);
        ivalid = 1'b1;
        idata  = {t, payload};
        ivch   = v;
        repeat (gap) begin
            @(negedge clk);
            ivalid = 1'b0;
        end
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr    = 1'b1;
        ivalid = 1'b0;
        @(negedge clk);
        clr    = 1'b0;
    endtask

    typedef struct {
        logic       clr;
        logic       valid;
        flit_type_e ftype;
        logic [1:0] vch;
        logic       exp_busy;
        logic       exp_done;
        logic [7:0] exp_len;
        logic [1:0] exp_vch;
        int         exp_pkt_cnt;
        int         exp_flit_cnt;
        logic [3:0] exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic c, input logic v, input flit_type_e t, input logic [1:0] ch,
                                input logic eb, input logic ed, input logic [7:0] el,
                                input logic [1:0] ev, input int ep, input int ef, input logic [3:0] ee);
        vec_t r;
        r.clr = c; r.valid = v; r.ftype = t; r.vch = ch;
        r.exp_busy = eb; r.exp_done = ed; r.exp_len = el; r.exp_vch = ev;
        r.exp_pkt_cnt = ep; r.exp_flit_cnt = ef; r.exp_err = ee;
        return r;
    endfunction

    task automatic apply(input vec_t v);
        clr    = v.clr;
        ivalid = v.valid;
        idata  = {v.ftype, 64'h0123_4567_89ab_cdef};
        ivch   = v.vch;
    endtask

    logic [63:0] pay;
    logic [CNT_W-1:0] exp_tog;

    initial begin
        rst_ = 1'b0; clr = 1'b0; ivalid = 1'b0; idata = '0; ivch = '0;

        // --- table: clr/valid/type/vch -> busy/done/len/vch/pkt_cnt/flit_cnt/err_code
        vecs.push_back(mk(1, 1, TYPE_HEAD, 0, 0, 0, 0, 0, 0, 0, 4'b0000)); // clr drops HEAD
        vecs.push_back(mk(0, 1, TYPE_DATA, 0, 0, 0, 0, 0, 0, 1, 4'b0001)); // orphan DATA
        vecs.push_back(mk(1, 0, TYPE_NONE, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 1, TYPE_HEAD, 2, 1, 0, 0, 0, 0, 1, 4'b0000));
        vecs.push_back(mk(0, 0, TYPE_DATA, 2, 1, 0, 0, 0, 0, 1, 4'b0000)); // bubble
        vecs.push_back(mk(0, 1, TYPE_TAIL, 2, 0, 1, 2, 2, 1, 2, 4'b0000)); // HEAD->TAIL
        vecs.push_back(mk(0, 0, TYPE_NONE, 0, 0, 0, 2, 2, 1, 2, 4'b0000));
        vecs.push_back(mk(1, 0, TYPE_NONE, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 1, TYPE_HEAD, 1, 1, 0, 0, 0, 0, 1, 4'b0000));
        vecs.push_back(mk(0, 1, TYPE_DATA, 1, 1, 0, 0, 0, 0, 2, 4'b0000));
        vecs.push_back(mk(0, 1, TYPE_HEAD, 1, 1, 0, 0, 0, 0, 3, 4'b0010)); // HEAD in packet
        vecs.push_back(mk(0, 1, TYPE_TAIL, 1, 0, 1, 2, 1, 1, 4, 4'b0010));
        vecs.push_back(mk(0, 1, TYPE_HEAD, 0, 1, 0, 2, 1, 1, 5, 4'b0010));
        vecs.push_back(mk(0, 1, TYPE_DATA, 3, 1, 0, 2, 1, 1, 6, 4'b0110)); // VC change
        vecs.push_back(mk(0, 1, TYPE_NONE, 0, 1, 0, 2, 1, 1, 7, 4'b0111)); // NONE in body
        vecs.push_back(mk(0, 1, TYPE_TAIL, 0, 0, 1, 3, 0, 2, 8, 4'b0111));
        vecs.push_back(mk(0, 0, TYPE_NONE, 0, 0, 0, 3, 0, 2, 8, 4'b0111));
        vecs.push_back(mk(1, 0, TYPE_NONE, 0, 0, 0, 0, 0, 0, 0, 4'b0000));

        // --- reset, then 10 idle cycles
        repeat (3) @(negedge clk);
        rst_ = 1'b1;
        repeat (10) @(negedge clk);
        check("rst busy", 64'(busy), 0);
        check("rst pkt_done", 64'(pkt_done), 0);
        check("rst pkt_len", 64'(pkt_len), 0);
        check("rst pkt_vch", 64'(pkt_vch), 0);
        check("rst pkt_cnt", 64'(pkt_cnt), 0);
        check("rst flit_cnt", 64'(flit_cnt), 0);
        check("rst toggle_cnt", 64'(toggle_cnt), 0);
        check("rst err", 64'(err), 0);
        check("rst err_code", 64'(err_code), 0);
        check("rst short busy", 64'(s_busy), 0);

        // --- table-driven framing vectors
        apply(vecs[0]);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check($sformatf("row%0d busy", i), 64'(busy), 64'(vecs[i].exp_busy));
            check($sformatf("row%0d pkt_done", i), 64'(pkt_done), 64'(vecs[i].exp_done));
            check($sformatf("row%0d pkt_len", i), 64'(pkt_len), 64'(vecs[i].exp_len));
            check($sformatf("row%0d pkt_vch", i), 64'(pkt_vch), 64'(vecs[i].exp_vch));
            check($sformatf("row%0d pkt_cnt", i), 64'(pkt_cnt), 64'(vecs[i].exp_pkt_cnt));
            check($sformatf("row%0d flit_cnt", i), 64'(flit_cnt), 64'(vecs[i].exp_flit_cnt));
            check($sformatf("row%0d err_code", i), 64'(err_code), 64'(vecs[i].exp_err));
            check($sformatf("row%0d err", i), 64'(err), 64'(|vecs[i].exp_err));
            if (i + 1 < vecs.size()) apply(vecs[i+1]);
            else begin clr = 1'b0; ivalid = 1'b0; end
        end

        // --- 22-flit packet on VC1, back to back
        do_clr();
        send(TYPE_HEAD, 1, 64'h0, 0);
        for (int k = 0; k < 20; k++) begin
            send(TYPE_DATA, 1, 64'(k), 0);
            if (k == 0) check("b2b busy mid-packet", 64'(busy), 1);
        end
        send(TYPE_TAIL, 1, 64'h0, 1);
        check("b2b pkt_done", 64'(pkt_done), 1);
        check("b2b pkt_len", 64'(pkt_len), 22);
        check("b2b pkt_vch", 64'(pkt_vch), 1);
        check("b2b pkt_cnt", 64'(pkt_cnt), 1);
        check("b2b flit_cnt", 64'(flit_cnt), 22);
        check("b2b err", 64'(err), 0);
        check("b2b busy after tail", 64'(busy), 0);
        @(negedge clk);
        check("b2b pkt_done one cycle", 64'(pkt_done), 0);

        // --- 10 packets with 7-cycle bubbles between flits
        do_clr();
        for (int p = 0; p < 10; p++) begin
            send(TYPE_HEAD, 1, 64'(p), 7);
            for (int k = 0; k < 20; k++) send(TYPE_DATA, 1, 64'(k), 7);
            send(TYPE_TAIL, 1, 64'h0, 7);
        end
        check("bubble pkt_cnt", 64'(pkt_cnt), 10);
        check("bubble flit_cnt", 64'(flit_cnt), 220);
        check("bubble pkt_len", 64'(pkt_len), 22);
        check("bubble err", 64'(err), 0);

        // --- switching activity: HEAD 0-payload, then DATA alternating 0 / all-ones
        do_clr();
        send(TYPE_HEAD, 0, 64'h0, 1);
        check("toggle after head", 64'(toggle_cnt), 1);
        exp_tog = 32'd1;
        for (int k = 1; k <= 10; k++) begin
            pay = (k % 2 == 1) ? 64'h0 : '1;
            send(TYPE_DATA, 0, pay, 1);
            exp_tog = (k == 1) ? exp_tog + 32'd2 : exp_tog + 32'd64;
            check($sformatf("toggle data%0d", k), 64'(toggle_cnt), 64'(exp_tog));
        end

        // --- asynchronous reset in the middle of a packet
        @(negedge clk);
        #2 rst_ = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 0);
        check("midrst flit_cnt", 64'(flit_cnt), 0);
        check("midrst toggle_cnt", 64'(toggle_cnt), 0);
        check("midrst pkt_done", 64'(pkt_done), 0);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        check("midrst pkt_cnt", 64'(pkt_cnt), 0);

        // --- length overflow on the LEN_W=3 instance: HEAD + 8 DATA + TAIL
        do_clr();
        send(TYPE_HEAD, 2, 64'h0, 0);
        for (int k = 0; k < 8; k++) send(TYPE_DATA, 2, 64'(k), 0);
        send(TYPE_TAIL, 2, 64'h0, 1);
        check("ovf pkt_done", 64'(s_pkt_done), 1);
        check("ovf pkt_len", 64'(s_pkt_len), 7);
        check("ovf err_code", 64'(s_err_code), 4'b1000);
        check("ovf err", 64'(s_err), 1);
        check("ovf pkt_cnt", 64'(s_pkt_cnt), 1);
        check("ovf flit_cnt", 64'(s_flit_cnt), 10);
        check("ovf wide pkt_len", 64'(pkt_len), 10);
        check("ovf wide err", 64'(err), 0);

        // --- clear with a valid HEAD in the same cycle
        @(negedge clk);
        clr = 1'b1; ivalid = 1'b1; idata = {TYPE_HEAD, 64'hffff}; ivch = 2'd3;
        @(negedge clk);
        clr = 1'b0; ivalid = 1'b0;
        check("clr busy", 64'(s_busy), 0);
        check("clr pkt_len", 64'(s_pkt_len), 0);
        check("clr pkt_vch", 64'(s_pkt_vch), 0);
        check("clr pkt_cnt", 64'(s_pkt_cnt), 0);
        check("clr flit_cnt", 64'(s_flit_cnt), 0);
        check("clr toggle_cnt", 64'(s_toggle_cnt), 0);
        check("clr err_code", 64'(s_err_code), 0);
        check("clr err", 64'(s_err), 0);
        @(negedge clk);
        check("clr head dropped busy", 64'(s_busy), 0);
        check("clr head dropped wide busy", 64'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
